// File: rtl/mult_seq_control.sv
// Register/sequencing half of a sequential signed shift-add multiplier.
// The per-iteration add/subtract lives in MUX_AND_SUM and returns through Product_Output.
module mult_seq_control #(
    parameter int Word_Length = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [Word_Length-1:0]   Multiplicand,
    input  logic [Word_Length-1:0]   Multiplier,
    output logic [2*Word_Length-1:0] Multiplicand_Input,
    output logic [Word_Length-1:0]   Multiplier_Input,
    output logic [Word_Length-1:0]   counter,
    output logic [2*Word_Length-1:0] Product_Input,
    output logic                     Shift_CA2,
    input  logic [2*Word_Length-1:0] Product_Output,
    output logic [2*Word_Length-1:0] Result,
    output logic                     busy,
    output logic                     done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [Word_Length-1:0] last_count = Word_Length'(Word_Length - 1);

    state_t state;
    state_t next_state;
    logic   last_iter;

    assign last_iter = (counter == last_count);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = CALC;
            CALC:    if (last_iter) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == CALC);
        done = (state == DONE);
    end

    // The final iteration only captures the result; the datapath registers keep their last values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Multiplicand_Input <= '0;
            Multiplier_Input   <= '0;
            counter            <= '0;
            Product_Input      <= '0;
            Shift_CA2          <= 1'b0;
            Result             <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        Multiplicand_Input <= {{Word_Length{Multiplicand[Word_Length-1]}}, Multiplicand};
                        Multiplier_Input   <= Multiplier;
                        counter            <= '0;
                        Product_Input      <= '0;
                        Shift_CA2          <= Multiplier[Word_Length-1];
                    end
                end
                CALC: begin
                    if (last_iter) begin
                        Result <= Product_Output;
                    end else begin
                        Product_Input      <= Product_Output;
                        Multiplicand_Input <= {Multiplicand_Input[2*Word_Length-2:0], 1'b0};
                        Multiplier_Input   <= {Shift_CA2, Multiplier_Input[Word_Length-1:1]};
                        counter            <= counter + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_control.sv
// Self-checking bench for mult_seq_control: models MUX_AND_SUM, tracks an arithmetic
// reference of every register per cycle, and pins it with hand-computed directed cases.
module tb_mult_seq_control;

    localparam int W = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  start = 1'b0;
    logic signed [W-1:0]   a_in = '0;
    logic signed [W-1:0]   b_in = '0;
    logic [2*W-1:0]        mcand_in;
    logic [W-1:0]          mplier_in;
    logic [W-1:0]          counter;
    logic [2*W-1:0]        pp_in;
    logic                  shift_ca2;
    logic [2*W-1:0]        prod_out;
    logic [2*W-1:0]        result;
    logic                  busy;
    logic                  done;

    int checks = 0;
    int failures = 0;

    mult_seq_control #(.Word_Length(W)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .start              (start),
        .Multiplicand       (a_in),
        .Multiplier         (b_in),
        .Multiplicand_Input (mcand_in),
        .Multiplier_Input   (mplier_in),
        .counter            (counter),
        .Product_Input      (pp_in),
        .Shift_CA2          (shift_ca2),
        .Product_Output     (prod_out),
        .Result             (result),
        .busy               (busy),
        .done               (done)
    );

    always #5 clk = ~clk;

    // Stand-in for the downstream MUX_AND_SUM block.
    always_comb begin
        prod_out = pp_in;
        if (mplier_in[0]) begin
            if (counter == W'(W - 1) && shift_ca2) prod_out = pp_in - mcand_in;
            else                                   prod_out = pp_in + mcand_in;
        end
    end

    task automatic check_val(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Reference: step -1 idle, 0..W-1 = iteration k, W = completion cycle.
    int                  m_step = -1;
    logic signed [W-1:0] m_a = '0;
    logic signed [W-1:0] m_b = '0;
    logic [2*W-1:0]      exp_mcand = '0;
    logic [2*W-1:0]      exp_pp = '0;
    logic [2*W-1:0]      exp_result = '0;
    logic [W-1:0]        exp_mplier = '0;
    logic [W-1:0]        exp_counter = '0;
    logic                exp_ca2 = 1'b0;
    logic                exp_busy = 1'b0;
    logic                exp_done = 1'b0;

    function automatic longint partial_sum(input logic signed [W-1:0] a, input logic [W-1:0] b, input int k);
        longint acc = 0;
        for (int i = 0; i < k; i++) begin
            if (b[i]) acc += longint'(a) * (longint'(1) << i);
        end
        return acc;
    endfunction

    task automatic set_iter(input int k);
        longint t;
        t = longint'(m_a) * (longint'(1) << k);
        exp_mcand = t[2*W-1:0];
        t = partial_sum(m_a, m_b, k);
        exp_pp = t[2*W-1:0];
        exp_mplier = m_b >>> k;
        exp_counter = k[W-1:0];
        exp_ca2 = (m_b < 0);
    endtask

    always @(posedge clk or negedge rst_n) begin
        longint p;
        if (!rst_n) begin
            m_step = -1;
            exp_mcand = '0; exp_pp = '0; exp_result = '0; exp_mplier = '0;
            exp_counter = '0; exp_ca2 = 1'b0; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            if (m_step == -1) begin
                if (start) begin
                    m_a = a_in;
                    m_b = b_in;
                    m_step = 0;
                    set_iter(0);
                end
            end else if (m_step < W - 1) begin
                m_step++;
                set_iter(m_step);
            end else if (m_step == W - 1) begin
                m_step = W;
                p = longint'(m_a) * longint'(m_b);
                exp_result = p[2*W-1:0];
            end else begin
                m_step = -1;
            end
            exp_busy = (m_step >= 0 && m_step < W);
            exp_done = (m_step == W);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check_val("cyc_busy", longint'(busy), longint'(exp_busy));
            check_val("cyc_done", longint'(done), longint'(exp_done));
            check_val("cyc_counter", longint'(counter), longint'(exp_counter));
            check_val("cyc_mcand", longint'(mcand_in), longint'(exp_mcand));
            check_val("cyc_mplier", longint'(mplier_in), longint'(exp_mplier));
            check_val("cyc_pp", longint'(pp_in), longint'(exp_pp));
            check_val("cyc_ca2", longint'(shift_ca2), longint'(exp_ca2));
            check_val("cyc_result", longint'(result), longint'(exp_result));
        end
    end

    int     seq_exp [8] = '{0, -5, -5, -5, -45, -125, -285, -605};
    longint pp_seen [$];

    // One operation with a single start pulse; optionally re-pulses start at a given counter value.
    task automatic apply_stimulus(input int a, input int b, input int pulse_at, input int res, input bit check_seq);
        int edges;
        int latency;
        int busy_cycles;
        int done_pulses;
        @(negedge clk);
        a_in = W'(a);
        b_in = W'(b);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        latency = -1;
        busy_cycles = 0;
        done_pulses = 0;
        pp_seen.delete();
        for (int n = 0; n < 14; n++) begin
            if (busy) begin
                busy_cycles++;
                pp_seen.push_back(longint'($signed(pp_in)));
            end
            if (done) begin
                done_pulses++;
                if (latency < 0) latency = edges;
            end
            start = (pulse_at >= 0 && busy && counter == W'(pulse_at));
            @(negedge clk);
            edges++;
        end
        start = 1'b0;
        check_val("latency_edges", latency, 9);
        check_val("busy_cycles", busy_cycles, 8);
        check_val("done_pulses", done_pulses, 1);
        check_val("result_literal", longint'($signed(result)), res);
        if (check_seq) begin
            check_val("pp_seq_len", pp_seen.size(), 8);
            for (int i = 0; i < 8 && i < pp_seen.size(); i++) begin
                check_val($sformatf("pp_seq[%0d]", i), pp_seen[i], seq_exp[i]);
            end
        end
    endtask

    int burst_a [3] = '{3, -1, 127};
    int burst_b [3] = '{-4, -1, 127};
    int burst_r [3] = '{-12, 1, 16129};

    initial begin
        int n;
        int idx;
        int last_done;

        #1 rst_n = 1'b0;
        #2;
        check_val("reset_result", longint'(result), 0);
        check_val("reset_busy", longint'(busy), 0);
        check_val("reset_done", longint'(done), 0);
        check_val("reset_counter", longint'(counter), 0);
        check_val("reset_pp", longint'(pp_in), 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        apply_stimulus(-5, -7, -1, 35, 1'b1);
        apply_stimulus(-128, 127, -1, -16256, 1'b0);
        apply_stimulus(-128, -128, -1, 16384, 1'b0);
        apply_stimulus(2, 10, -1, 20, 1'b0);
        apply_stimulus(0, -1, -1, 0, 1'b0);
        apply_stimulus(3, 4, 3, 12, 1'b0);

        // Abandon an operation with an asynchronous reset mid-calculation.
        @(negedge clk);
        a_in = 8'sd7;
        b_in = 8'sd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (counter != 8'd4 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("reach_counter4", longint'(counter), 4);
        #2 rst_n = 1'b0;
        #1;
        check_val("async_result", longint'(result), 0);
        check_val("async_pp", longint'(pp_in), 0);
        check_val("async_mcand", longint'(mcand_in), 0);
        check_val("async_mplier", longint'(mplier_in), 0);
        check_val("async_counter", longint'(counter), 0);
        check_val("async_ca2", longint'(shift_ca2), 0);
        check_val("async_busy", longint'(busy), 0);
        check_val("async_done", longint'(done), 0);
        repeat (3) begin
            @(negedge clk);
            check_val("done_in_reset", longint'(done), 0);
        end
        rst_n = 1'b1;
        check_val("result_after_abort", longint'(result), 0);
        apply_stimulus(7, 9, -1, 63, 1'b0);

        // Start held high: three back-to-back operations.
        @(negedge clk);
        a_in = W'(burst_a[0]);
        b_in = W'(burst_b[0]);
        start = 1'b1;
        idx = 0;
        last_done = -1;
        for (int k = 0; k < 45 && idx < 3; k++) begin
            @(negedge clk);
            if (done) begin
                check_val($sformatf("burst_result[%0d]", idx), longint'($signed(result)), burst_r[idx]);
                if (idx > 0) check_val("burst_spacing", k - last_done, 10);
                last_done = k;
                idx++;
                if (idx < 3) begin
                    a_in = W'(burst_a[idx]);
                    b_in = W'(burst_b[idx]);
                end
            end
        end
        start = 1'b0;
        check_val("burst_count", idx, 3);
        repeat (4) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq_control.md
MULT_SEQ_CONTROL -- requirements
Module: mult_seq_control

Interface
REQ-001 Parameter Word_Length, default 8; the width W of each signed operand; the product is 2W bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request to begin a multiplication; sampled only in IDLE.
REQ-005 Multiplicand  input  W  signed two's-complement operand A.
REQ-006 Multiplier  input  W  signed two's-complement operand B.
REQ-007 Multiplicand_Input  output  2W  to MUX_AND_SUM; sign-extended A, shifted left once per iteration.
REQ-008 Multiplier_Input  output  W  to MUX_AND_SUM; B, shifted right once per iteration.
REQ-009 counter  output  W  to MUX_AND_SUM; iteration index 0..W-1.
REQ-010 Product_Input  output  2W  to MUX_AND_SUM; registered partial product.
REQ-011 Shift_CA2  output  1  to MUX_AND_SUM; copy of B[W-1] captured at load.
REQ-012 Product_Output  input  2W  from MUX_AND_SUM; next partial product (combinational in MUX_AND_SUM).
REQ-013 Result  output  2W  signed final product; held until the next completion.
REQ-014 busy  output  1  high while in CALC.
REQ-015 done  output  1  one-cycle completion pulse.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, CALC and DONE, encoded and registered.
REQ-017 In IDLE with start=1, the next edge SHALL load:
- Multiplicand_Input = sign-extended A
- Multiplier_Input = B
- counter = 0
- Product_Input = 0
- Shift_CA2 = B[W-1]
- state = CALC
REQ-018 In IDLE with start=0, all registers SHALL hold.
REQ-019 In CALC, while counter < W-1, each edge SHALL update:
- Product_Input <= Product_Output
- Multiplicand_Input <= Multiplicand_Input << 1 (zero fill)
- Multiplier_Input <= Multiplier_Input >> 1, with the MSB filled from Shift_CA2 (arithmetic shift when negative)
- counter <= counter + 1
REQ-020 In CALC with counter == W-1, the edge SHALL set Result <= Product_Output and state <= DONE, and SHALL hold the datapath registers.
REQ-021 Downstream contract: Product_Output = Product_Input + Multiplicand_Input when Multiplier_Input[0]=1, except at counter == W-1 with Shift_CA2=1, where it is Product_Input - Multiplicand_Input; otherwise it is Product_Input. All arithmetic is 2W-bit modulo.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-023 Latency: if start is sampled at edge E, done SHALL be high during the cycle after edge E+W (W=8 gives 9 edges from start to done).
REQ-024 start SHALL be ignored in CALC and DONE; no restart or abort mid-operation.
REQ-025 start held high continuously SHALL begin a new operation on the first IDLE cycle after DONE, giving back-to-back operations with one IDLE cycle between them.
REQ-026 busy = (state==CALC) and done = (state==DONE), both decoded from registered state only.
REQ-027 Result SHALL be correct for all signed W-bit pairs, including -2^(W-1) * -2^(W-1) = +2^(2W-2).

Reset
REQ-028 rst_n=0 SHALL immediately, regardless of clk:
- force state to IDLE
- clear every register and output to 0 (Result, Product_Input, Multiplicand_Input, Multiplier_Input, counter, Shift_CA2, busy, done)
REQ-029 A reset during CALC SHALL abandon the operation: no done pulse, and Result reads 0.
REQ-030 The first start after reset release SHALL be accepted on the first rising edge at which rst_n=1 and start=1.

Verification
REQ-031 A=-5, B=-7, start pulse -> Product_Input sequence 0,-5,-5,-5,-45,-125,-285,-605; Result=35; done exactly 9 edges after start.
REQ-032 A=-128, B=127 -> Result=-16256 (0xC080); A=-128, B=-128 -> Result=16384 (0x4000).
REQ-033 A=2, B=10 -> Result=20, busy high for 8 cycles; A=0, B=-1 -> Result=0.
REQ-034 start pulsed at counter=3 of an A=3, B=4 run -> ignored, Result=12, single done pulse.
REQ-035 rst_n low at counter=4 of an A=7, B=9 run -> all outputs 0 asynchronously, no done; a fresh A=7, B=9 run then gives Result=63.
REQ-036 start held high for three operations -> three done pulses spaced 10 cycles apart, each Result correct.
